// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with wrap/saturate, clear, load and boundary pulses
module param_updown_counter #(
    parameter int unsigned          WIDTH    = 8,
    parameter logic [WIDTH-1:0]     MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                   SATURATE = 1'b0,
    parameter int unsigned          STEP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf,
    output logic              unf
);

    // Comparisons run one bit wider so count + s never truncates before the MAX_VAL test.
    localparam logic [WIDTH:0]   MAX_X  = {1'b0, MAX_VAL};
    localparam logic [WIDTH-1:0] MOD_LO = MAX_VAL + WIDTH'(1);

    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   s_x;
    logic [WIDTH-1:0] s_lo;
    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH-1:0] load_clamped;

    logic [WIDTH-1:0] next_count;
    logic             next_ovf;
    logic             next_unf;

    assign step_x       = (WIDTH+1)'(step);
    assign s_x          = (step_x > MAX_X) ? MAX_X : step_x;
    assign s_lo         = s_x[WIDTH-1:0];
    assign count_x      = {1'b0, count};
    assign sum_x        = count_x + s_x;
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Wrap results only need the low WIDTH bits; the modulus arithmetic is exact mod 2**WIDTH.
    always_comb begin
        next_count = count;
        next_ovf   = 1'b0;
        next_unf   = 1'b0;
        if (clr) begin
            next_count = '0;
        end else if (load) begin
            next_count = load_clamped;
        end else if (en) begin
            if (up_down) begin
                if (sum_x <= MAX_X) begin
                    next_count = sum_x[WIDTH-1:0];
                end else begin
                    next_ovf   = 1'b1;
                    next_count = SATURATE ? MAX_VAL : (sum_x[WIDTH-1:0] - MOD_LO);
                end
            end else begin
                if (count_x >= s_x) begin
                    next_count = count - s_lo;
                end else begin
                    next_unf   = 1'b1;
                    next_count = SATURATE ? '0 : (count + MOD_LO - s_lo);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= next_count;
            ovf   <= next_ovf;
            unf   <= next_unf;
        end
    end

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - directed scoreboard bench for a wrapping and a saturating counter
module tb_param_updown_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Wrapping instance: WIDTH=4, MAX_VAL=9
    logic       w_clr, w_load, w_en, w_ud;
    logic [3:0] w_lv, w_step, w_count;
    logic       w_at_max, w_at_min, w_ovf, w_unf;

    // Saturating instance: WIDTH=8, MAX_VAL=200
    logic       s_clr, s_load, s_en, s_ud;
    logic [7:0] s_lv, s_count;
    logic [3:0] s_step;
    logic       s_at_max, s_at_min, s_ovf, s_unf;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .STEP_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .load(w_load), .load_val(w_lv), .en(w_en),
        .up_down(w_ud), .step(w_step), .count(w_count), .at_max(w_at_max), .at_min(w_at_min),
        .ovf(w_ovf), .unf(w_unf));

    param_updown_counter #(.WIDTH(8), .MAX_VAL(8'd200), .SATURATE(1'b1), .STEP_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .load(s_load), .load_val(s_lv), .en(s_en),
        .up_down(s_ud), .step(s_step), .count(s_count), .at_max(s_at_max), .at_min(s_at_min),
        .ovf(s_ovf), .unf(s_unf));

    typedef struct {
        bit    sel;
        int    cnt;
        logic  ovf;
        logic  unf;
        string tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input bit sel, input int cnt, input logic eo, input logic eu, input string tag);
        int mx;
        mx = sel ? 200 : 9;
        if (sel) begin
            check({tag, ".count"},  32'(s_count),  32'(cnt));
            check({tag, ".ovf"},    32'(s_ovf),    32'(eo));
            check({tag, ".unf"},    32'(s_unf),    32'(eu));
            check({tag, ".at_max"}, 32'(s_at_max), 32'(cnt == mx));
            check({tag, ".at_min"}, 32'(s_at_min), 32'(cnt == 0));
        end else begin
            check({tag, ".count"},  32'(w_count),  32'(cnt));
            check({tag, ".ovf"},    32'(w_ovf),    32'(eo));
            check({tag, ".unf"},    32'(w_unf),    32'(eu));
            check({tag, ".at_max"}, 32'(w_at_max), 32'(cnt == mx));
            check({tag, ".at_min"}, 32'(w_at_min), 32'(cnt == 0));
        end
    endtask

    // Drive one cycle of stimulus on the selected instance, queue its expectation, clock, then compare.
    task automatic cyc(input bit sel, input logic c, input logic l, input int lv, input logic e,
                       input logic ud, input int st, input int ec, input logic eo, input logic eu,
                       input string tag);
        exp_t x;
        w_clr = 0; w_load = 0; w_lv = 0; w_en = 0; w_ud = 0; w_step = 0;
        s_clr = 0; s_load = 0; s_lv = 0; s_en = 0; s_ud = 0; s_step = 0;
        if (sel) begin
            s_clr = c; s_load = l; s_lv = 8'(lv); s_en = e; s_ud = ud; s_step = 4'(st);
        end else begin
            w_clr = c; w_load = l; w_lv = 4'(lv); w_en = e; w_ud = ud; w_step = 4'(st);
        end
        q.push_back('{sel, ec, eo, eu, tag});
        @(posedge clk);
        #1;
        x = q.pop_front();
        check_dut(x.sel, x.cnt, x.ovf, x.unf, x.tag);
    endtask

    initial begin
        w_clr = 0; w_load = 0; w_lv = 0; w_en = 0; w_ud = 0; w_step = 0;
        s_clr = 0; s_load = 0; s_lv = 0; s_en = 0; s_ud = 0; s_step = 0;

        // Reset state, with enables active to show they are ignored
        w_en = 1; w_ud = 1; w_step = 1;
        repeat (2) @(posedge clk);
        #1;
        check_dut(0, 0, 0, 0, "rst_wrap");
        check_dut(1, 0, 0, 0, "rst_sat");
        @(negedge clk);
        rst_n = 1;

        // Count up through the wrap, then reset mid-pulse
        for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 0, 1, 1, 1, i, 0, 0, $sformatf("up%0d", i));
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, "up_wrap");
        rst_n = 0;
        #1;
        check_dut(0, 0, 0, 0, "rst_mid");
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, "rst_hold0");
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, "rst_hold1");
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 0, 1, 1, 1, i, 0, 0, $sformatf("up2_%0d", i));
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, "up2_wrap");
        cyc(0, 0, 0, 0, 1, 1, 1, 1, 0, 0, "up2_after");

        // Wrap down with step 3
        cyc(0, 0, 1, 2, 0, 0, 0, 2, 0, 0, "dn_load2");
        cyc(0, 0, 0, 0, 1, 0, 3, 9, 0, 1, "dn_9");
        cyc(0, 0, 0, 0, 1, 0, 3, 6, 0, 0, "dn_6");
        cyc(0, 0, 0, 0, 1, 0, 3, 3, 0, 0, "dn_3");
        cyc(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, "dn_0");
        cyc(0, 0, 0, 0, 1, 0, 3, 7, 0, 1, "dn_7");

        // Priority: clr > load > en
        cyc(0, 0, 1, 5, 0, 0, 0, 5, 0, 0, "pri_load5");
        cyc(0, 1, 1, 7, 1, 1, 1, 0, 0, 0, "pri_clr");
        cyc(0, 0, 1, 7, 1, 1, 1, 7, 0, 0, "pri_load");
        cyc(0, 0, 0, 0, 1, 1, 1, 8, 0, 0, "pri_step");

        // Clamping of load_val and step
        cyc(0, 0, 1, 14, 0, 0, 0, 9, 0, 0, "clamp_load");
        cyc(0, 0, 1, 3, 0, 0, 0, 3, 0, 0, "clamp_load3");
        cyc(0, 0, 0, 0, 1, 1, 15, 2, 1, 0, "clamp_step");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clr_only");

        // Hold: idle cycles, then enabled with step 0
        cyc(0, 0, 1, 4, 0, 0, 0, 4, 0, 0, "hold_load4");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 5, 4, 0, 0, $sformatf("hold_idle%0d", i));
        cyc(0, 0, 0, 0, 1, 1, 0, 4, 0, 0, "hold_step0_up");
        cyc(0, 0, 0, 0, 1, 0, 0, 4, 0, 0, "hold_step0_dn");

        // Saturating instance
        cyc(1, 0, 1, 198, 0, 0, 0, 198, 0, 0, "sat_load198");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1, 5, 200, 1, 0, $sformatf("sat_up%0d", i));
        cyc(1, 0, 1, 10, 0, 0, 0, 10, 0, 0, "sat_load10");
        cyc(1, 0, 0, 0, 1, 0, 15, 0, 0, 1, "sat_dn0");
        cyc(1, 0, 0, 0, 1, 0, 15, 0, 0, 1, "sat_dn1");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_idle");
        cyc(1, 0, 0, 0, 1, 1, 5, 5, 0, 0, "sat_up_norm");
        cyc(1, 0, 1, 255, 0, 0, 0, 200, 0, 0, "sat_load_clamp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
